// File: rtl/fdtd_mem_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the FDTD write master
// and the plugin AXI port.
interface fdtd_mem_wr_if #(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 32,
   parameter int AXI4_ID_WIDTH   = 16,
   parameter int AXI4_USER_WIDTH = 10,
   parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8
);
   logic [AXI4_ID_WIDTH-1:0]   AWID_o;
   logic [AXI4_ADDR_WIDTH-1:0] AWADDR_o;
   logic [7:0]                 AWLEN_o;
   logic [2:0]                 AWSIZE_o;
   logic [1:0]                 AWBURST_o;
   logic                       AWLOCK_o;
   logic [3:0]                 AWCACHE_o;
   logic [2:0]                 AWPROT_o;
   logic [3:0]                 AWREGION_o;
   logic [AXI4_USER_WIDTH-1:0] AWUSER_o;
   logic [3:0]                 AWQOS_o;
   logic                       AWVALID_o;
   logic                       AWREADY_i;

   logic [AXI4_DATA_WIDTH-1:0] WDATA_o;
   logic [AXI_STRB_WIDTH-1:0]  WSTRB_o;
   logic                       WLAST_o;
   logic [AXI4_USER_WIDTH-1:0] WUSER_o;
   logic                       WVALID_o;
   logic                       WREADY_i;

   logic [AXI4_ID_WIDTH-1:0]   BID_i;
   logic [1:0]                 BRESP_i;
   logic [AXI4_USER_WIDTH-1:0] BUSER_i;
   logic                       BVALID_i;
   logic                       BREADY_o;

   modport master (
      output AWID_o, AWADDR_o, AWLEN_o, AWSIZE_o, AWBURST_o, AWLOCK_o,
             AWCACHE_o, AWPROT_o, AWREGION_o, AWUSER_o, AWQOS_o, AWVALID_o,
             WDATA_o, WSTRB_o, WLAST_o, WUSER_o, WVALID_o, BREADY_o,
      input  AWREADY_i, WREADY_i, BID_i, BRESP_i, BUSER_i, BVALID_i
   );

   modport slave (
      input  AWID_o, AWADDR_o, AWLEN_o, AWSIZE_o, AWBURST_o, AWLOCK_o,
             AWCACHE_o, AWPROT_o, AWREGION_o, AWUSER_o, AWQOS_o, AWVALID_o,
             WDATA_o, WSTRB_o, WLAST_o, WUSER_o, WVALID_o, BREADY_o,
      output AWREADY_i, WREADY_i, BID_i, BRESP_i, BUSER_i, BVALID_i
   );
endinterface

// File: rtl/fdtd_mem_wr.sv
// FDTD AXI4 write master: one outstanding INCR burst, AW then streamed W
// with generated WLAST, then B collected into a grant pulse and error flag.
module fdtd_mem_wr #(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 32,
   parameter int AXI4_ID_WIDTH   = 16,
   parameter int AXI4_USER_WIDTH = 10,
   parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   fdtd_mem_wr_if.master              axi,
   input  logic [7:0]                 axi_lenth_i,
   input  logic                       wr_req_i,
   input  logic [AXI4_ADDR_WIDTH-1:0] wr_word_addr_i,
   input  logic [AXI4_DATA_WIDTH-1:0] wr_data_i,
   input  logic                       wr_dvalid_i,
   output logic                       wr_dready_o,
   output logic                       wr_gnt_o,
   output logic                       wr_err_o
);
   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

   state_t                     state_q, state_d;
   logic [7:0]                 beat_cnt_q, beat_cnt_d;
   logic [7:0]                 awlen_q, awlen_d;
   logic [AXI4_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                       err_q, err_d;

   logic awvalid, wvalid, wlast, bready, gnt;
   logic unused_b;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= 8'd0;
         awlen_q    <= 8'd0;
         addr_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         awlen_q    <= awlen_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      awlen_d    = awlen_q;
      addr_d     = addr_q;
      err_d      = err_q;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wlast      = 1'b0;
      bready     = 1'b0;
      gnt        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (wr_req_i) begin
               addr_d  = wr_word_addr_i;
               // 8-bit wrap: a length of 0 encodes a 256-beat burst
               awlen_d = axi_lenth_i - 8'd1;
               state_d = S_AW;
            end
         end
         S_AW: begin
            awvalid = 1'b1;
            if (axi.AWREADY_i) begin
               beat_cnt_d = 8'd0;
               state_d    = S_W;
            end
         end
         S_W: begin
            wvalid = wr_dvalid_i;
            wlast  = (beat_cnt_q == awlen_q);
            if (wvalid && axi.WREADY_i) begin
               if (wlast) state_d = S_B;
               else beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         S_B: begin
            bready = 1'b1;
            if (axi.BVALID_i) begin
               err_d   = (axi.BRESP_i != 2'b00);
               gnt     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign axi.AWID_o     = '0;
   assign axi.AWADDR_o   = addr_q;
   assign axi.AWLEN_o    = awlen_q;
   assign axi.AWSIZE_o   = 3'd2;
   assign axi.AWBURST_o  = 2'b01;
   assign axi.AWLOCK_o   = 1'b0;
   assign axi.AWCACHE_o  = 4'd0;
   assign axi.AWPROT_o   = 3'd0;
   assign axi.AWREGION_o = 4'd0;
   assign axi.AWUSER_o   = '0;
   assign axi.AWQOS_o    = 4'd0;
   assign axi.AWVALID_o  = awvalid;

   assign axi.WDATA_o  = wr_data_i;
   assign axi.WSTRB_o  = '1;
   assign axi.WLAST_o  = wlast;
   assign axi.WUSER_o  = '0;
   assign axi.WVALID_o = wvalid;
   assign axi.BREADY_o = bready;

   assign wr_dready_o = wvalid & axi.WREADY_i;
   assign wr_gnt_o    = gnt;
   // error is presented in the grant cycle itself and then held
   assign wr_err_o    = err_d;

   // single-ID master: BID/BUSER carry nothing it needs
   assign unused_b = ^{axi.BID_i, axi.BUSER_i};
endmodule

// File: tb/tb_fdtd_mem_wr.sv
// Bench for fdtd_mem_wr: table of bursts, randomized slave/source timing,
// reset mid-burst, and random bursts checked against a burst-level model.
module tb_fdtd_mem_wr;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  lenth;
   logic        req;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        dvalid;
   logic        dready;
   logic        gnt;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fdtd_mem_wr_if ax ();

   fdtd_mem_wr dut (
      .ACLK           (clk),
      .ARESET         (rst),
      .axi            (ax),
      .axi_lenth_i    (lenth),
      .wr_req_i       (req),
      .wr_word_addr_i (waddr),
      .wr_data_i      (wdata),
      .wr_dvalid_i    (dvalid),
      .wr_dready_o    (dready),
      .wr_gnt_o       (gnt),
      .wr_err_o       (err)
   );

   typedef struct {
      logic [7:0]  len;
      logic [31:0] addr;
      logic [1:0]  bresp;
      int          aw_dly;
      int          wr_mode;
      int          dv_mode;
      int          dmode;
      int          exp_awlen;
      int          exp_beats;
      logic        exp_err;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_burst(input logic [7:0] len, input logic [31:0] addr,
                            input logic [1:0] bresp, input int aw_dly,
                            input int wr_mode, input int dv_mode,
                            input int dmode, input int exp_awlen,
                            input int exp_beats, input logic exp_err);
      logic [31:0] dq [$];
      logic [46:0] attr;
      logic [46:0] attr_exp;
      logic [31:0] prev_wd;
      logic [31:0] prev_aa;
      logic [7:0]  prev_al;
      bit          aw_done, w_done, b_done, w_stall, aw_stall;
      bit          aw_hs, w_end;
      int          cyc, bi, bwait, bdly, gnts;
      attr_exp = {16'h0, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 10'h0, 4'h0};
      for (int k = 0; k < exp_beats; k++)
         dq.push_back(dmode == 0 ? (k + 1) * 32'h11 : $urandom);
      aw_done = 0; w_done = 0; b_done = 0; w_stall = 0; aw_stall = 0;
      cyc = 0; bi = 0; bwait = 0; gnts = 0;
      bdly = $urandom_range(0, 3);
      prev_wd = '0; prev_aa = '0; prev_al = '0;
      @(negedge clk);
      req = 1'b1; lenth = len; waddr = addr;
      while (!b_done && cyc < 6000) begin
         ax.AWREADY_i = aw_done ? 1'b0 : (cyc > aw_dly);
         case (wr_mode)
            0: ax.WREADY_i = 1'b1;
            1: ax.WREADY_i = cyc[0];
            default: ax.WREADY_i = 1'($urandom_range(0, 1));
         endcase
         dvalid = (dv_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
         wdata = (bi < dq.size()) ? dq[bi] : 32'hDEAD_BEEF;
         ax.BVALID_i = w_done && (bwait >= bdly);
         ax.BRESP_i = bresp;
         ax.BID_i = 16'($urandom);
         ax.BUSER_i = 10'($urandom);
         if (w_done) bwait++;
         #1;
         chk("awvalid", ax.AWVALID_o, (cyc > 0) && !aw_done);
         chk("wvalid", ax.WVALID_o, aw_done && !w_done && dvalid);
         chk("bready", ax.BREADY_o, w_done);
         chk("dready", dready, aw_done && !w_done && dvalid && ax.WREADY_i);
         chk("gnt", gnt, w_done && ax.BVALID_i);
         if (aw_stall) begin
            chk("awaddr_stable", ax.AWADDR_o, prev_aa);
            chk("awlen_stable", ax.AWLEN_o, prev_al);
         end
         if (w_stall && ax.WVALID_o)
            chk("wdata_stable", ax.WDATA_o, prev_wd);
         aw_hs = ax.AWVALID_o && ax.AWREADY_i;
         aw_stall = ax.AWVALID_o && !ax.AWREADY_i;
         prev_aa = ax.AWADDR_o;
         prev_al = ax.AWLEN_o;
         if (aw_hs) begin
            chk("awaddr", ax.AWADDR_o, addr);
            chk("awlen", ax.AWLEN_o, exp_awlen);
            attr = {ax.AWID_o, ax.AWSIZE_o, ax.AWBURST_o, ax.AWLOCK_o,
                    ax.AWCACHE_o, ax.AWPROT_o, ax.AWREGION_o, ax.AWUSER_o,
                    ax.AWQOS_o};
            chk("aw_attr", attr, attr_exp);
            chk("wstrb_wuser", {ax.WSTRB_o, ax.WUSER_o}, {4'hF, 10'h0});
         end
         w_end = 0;
         w_stall = ax.WVALID_o && !ax.WREADY_i;
         prev_wd = ax.WDATA_o;
         if (ax.WVALID_o && ax.WREADY_i) begin
            chk("wdata", ax.WDATA_o, (bi < dq.size()) ? dq[bi] : 32'hDEAD_BEEF);
            chk("wlast", ax.WLAST_o, bi == exp_beats - 1);
            bi++;
            if (bi >= exp_beats) w_end = 1;
         end
         if (gnt) begin
            gnts++;
            chk("err_at_gnt", err, exp_err);
            b_done = 1;
         end
         if (aw_hs) aw_done = 1;
         if (w_end) w_done = 1;
         @(negedge clk);
         cyc++;
      end
      chk("burst_done", b_done, 1'b1);
      chk("beat_count", bi, exp_beats);
      chk("gnt_count", gnts, 1);
      req = 1'b0;
      ax.BVALID_i = 1'b0;
      ax.AWREADY_i = 1'b0;
      #1;
      chk("err_held", err, exp_err);
      chk("gnt_low_after", gnt, 1'b0);
      chk("awvalid_idle", ax.AWVALID_o, 1'b0);
   endtask

   initial begin
      logic [7:0] rl;
      logic [1:0] rb;
      vt[0] = '{8'd1, 32'h1A10_0000, 2'd0, 0, 0, 0, 0, 8'h00, 1, 1'b0};
      vt[1] = '{8'd4, 32'h1A10_0100, 2'd0, 0, 1, 0, 0, 8'h03, 4, 1'b0};
      vt[2] = '{8'd2, 32'h2000_0040, 2'd0, 5, 0, 0, 1, 8'h01, 2, 1'b0};
      vt[3] = '{8'd8, 32'h3000_0000, 2'd0, 1, 0, 1, 1, 8'h07, 8, 1'b0};
      vt[4] = '{8'd0, 32'h4000_0000, 2'd0, 2, 2, 1, 1, 8'hFF, 256, 1'b0};
      vt[5] = '{8'd3, 32'h5000_0010, 2'd2, 0, 2, 1, 1, 8'h02, 3, 1'b1};
      vt[6] = '{8'd5, 32'h5000_0100, 2'd0, 3, 2, 1, 1, 8'h04, 5, 1'b0};
      vt[7] = '{8'd2, 32'h6000_0000, 2'd3, 0, 0, 0, 1, 8'h01, 2, 1'b1};

      rst = 1'b1; req = 1'b0; lenth = '0; waddr = '0; wdata = '0;
      dvalid = 1'b0;
      ax.AWREADY_i = 1'b0; ax.WREADY_i = 1'b0; ax.BVALID_i = 1'b0;
      ax.BRESP_i = 2'b00; ax.BID_i = '0; ax.BUSER_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_awvalid", ax.AWVALID_o, 1'b0);
      chk("rst_wvalid", ax.WVALID_o, 1'b0);
      chk("rst_bready", ax.BREADY_o, 1'b0);
      chk("rst_gnt_err", {gnt, err}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_burst(vt[i].len, vt[i].addr, vt[i].bresp, vt[i].aw_dly,
                   vt[i].wr_mode, vt[i].dv_mode, vt[i].dmode,
                   vt[i].exp_awlen, vt[i].exp_beats, vt[i].exp_err);

      // reset during the third beat of an 8-beat burst, error flag still set
      @(negedge clk);
      req = 1'b1; lenth = 8'd8; waddr = 32'h7000_0000;
      ax.AWREADY_i = 1'b1; ax.WREADY_i = 1'b1; dvalid = 1'b1;
      repeat (4) @(negedge clk);
      ax.AWREADY_i = 1'b0;
      #1;
      chk("pre_rst_wvalid", ax.WVALID_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_awvalid", ax.AWVALID_o, 1'b0);
      chk("mid_rst_wvalid", ax.WVALID_o, 1'b0);
      chk("mid_rst_wlast", ax.WLAST_o, 1'b0);
      chk("mid_rst_bready", ax.BREADY_o, 1'b0);
      chk("mid_rst_gnt_err", {gnt, err}, 2'b00);
      chk("mid_rst_aw_regs", {ax.AWADDR_o, ax.AWLEN_o}, 40'h0);
      req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_burst(8'd3, 32'h7100_0000, 2'd0, 1, 2, 1, 1, 8'h02, 3, 1'b0);

      for (int i = 0; i < 12; i++) begin
         rl = 8'($urandom_range(1, 24));
         rb = 2'($urandom_range(0, 3));
         run_burst(rl, $urandom & 32'hFFFF_FFFC, rb, $urandom_range(0, 4),
                   $urandom_range(0, 2), $urandom_range(0, 1), 1,
                   (int'(rl) + 255) % 256, int'(rl), rb != 2'b00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
